sub_bytes_seq: RTL and testbench

- Sequential, parametrised AES SubBytes unit. It takes a 128-bit AES state and substitutes all 16 bytes using LANES parallel S-box lookups per cycle, so it finishes in 16/LANES cycles.
- Supports forward (cipher) and, optionally, inverse (decipher) substitution, selected per transaction.
- Sits between the round-key/ShiftRows stages of the round datapath. Valid/ready handshakes on both sides let area be traded against throughput.

---
 rtl/sub_bytes_seq.sv | 148 ++++++++++++++
 tb/tb_sub_bytes_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: AES SubBytes over a 128-bit state, LANES bytes per cycle, forward or inverse.
// Latency: out_valid rises 16/LANES cycles after the accepting edge; one state in flight at a time.
// Backpressure: result is held in DONE until out_ready; in_ready is low from acceptance to the output handshake.
//
// Ports:
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_data = state (byte 0 in [127:120]), in_inv = inverse mode
//   out_valid/out_ready  output handshake; out_data = substituted state, same byte ordering
//   busy                 high while a state is being processed or waiting to be taken

// Forward AES S-box: one combinational byte lookup.
module SBox (
  input  logic [7:0] addr,
  output logic [7:0] dout
);
  // Entry for address a sits at bits [(255-a)*8 +: 8], i.e. address 0 in the MSB byte.
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign dout = TBL[{~addr, 3'b000} +: 8];
endmodule

module sub_bytes_seq #(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int BEATS = 16 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = LANES * 8;

  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [127:0]    data_q, data_d;
  logic            inv_q, inv_d;

  // The current beat's bytes are brought to the top of the word, looked up,
  // then shifted back and merged under a mask so the rest stays in place.
  logic [6:0]      shamt;
  logic [127:0]    win;
  logic [LW-1:0]   lanes_cat;
  logic [127:0]    upd_top, mask_top, merged;

  assign shamt    = 7'(beat_q) * 7'(LW);
  assign win      = data_q << shamt;
  assign upd_top  = 128'(lanes_cat) << (128 - LW);
  assign mask_top = 128'({LW{1'b1}}) << (128 - LW);
  assign merged   = (data_q & ~(mask_top >> shamt)) | (upd_top >> shamt);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] lane_in, fwd_out;
    assign lane_in = win[127-8*l -: 8];

    SBox u_sbox (.addr(lane_in), .dout(fwd_out));

    if (INV_EN) begin : g_inv
      logic [7:0] inv_out;
      assign inv_out = INV_TBL[{~lane_in, 3'b000} +: 8];
      assign lanes_cat[LW-1-8*l -: 8] = inv_q ? inv_out : fwd_out;
    end else begin : g_fwd_only
      assign lanes_cat[LW-1-8*l -: 8] = fwd_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          beat_d  = '0;
          data_d  = in_data;
          inv_d   = in_inv & INV_EN;  // mode flag stays 0 when no inverse path exists
        end
      end
      S_RUN: begin
        data_d = merged;
        if (beat_q == CW'(BEATS - 1)) begin
          state_d = S_DONE;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
module tb_sub_bytes_seq;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: LANES=4 with inverse path, driven by the a_* inputs.
  logic         a_in_valid, a_in_inv, a_out_ready;
  logic [127:0] a_in_data;
  // Instances 1..5: LANES=1,2,8,16 and a forward-only LANES=4, all driven by s_*.
  logic         s_in_valid, s_in_inv, s_out_ready;
  logic [127:0] s_in_data;

  logic [5:0]   ov, ir, bz;
  logic [127:0] od [6];

  int n_chk  = 0;
  int n_fail = 0;
  int first_done [6];
  int exp_lat [6] = '{4, 16, 8, 2, 1, 4};

  sub_bytes_seq #(.LANES(4),  .INV_EN(1'b1)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(ir[0]), .in_data(a_in_data),
    .in_inv(a_in_inv), .out_valid(ov[0]), .out_ready(a_out_ready), .out_data(od[0]), .busy(bz[0]));
  sub_bytes_seq #(.LANES(1),  .INV_EN(1'b1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(ir[1]), .in_data(s_in_data),
    .in_inv(s_in_inv), .out_valid(ov[1]), .out_ready(s_out_ready), .out_data(od[1]), .busy(bz[1]));
  sub_bytes_seq #(.LANES(2),  .INV_EN(1'b1)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(ir[2]), .in_data(s_in_data),
    .in_inv(s_in_inv), .out_valid(ov[2]), .out_ready(s_out_ready), .out_data(od[2]), .busy(bz[2]));
  sub_bytes_seq #(.LANES(8),  .INV_EN(1'b1)) u_l8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(ir[3]), .in_data(s_in_data),
    .in_inv(s_in_inv), .out_valid(ov[3]), .out_ready(s_out_ready), .out_data(od[3]), .busy(bz[3]));
  sub_bytes_seq #(.LANES(16), .INV_EN(1'b1)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(ir[4]), .in_data(s_in_data),
    .in_inv(s_in_inv), .out_valid(ov[4]), .out_ready(s_out_ready), .out_data(od[4]), .busy(bz[4]));
  sub_bytes_seq #(.LANES(4),  .INV_EN(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(ir[5]), .in_data(s_in_data),
    .in_inv(s_in_inv), .out_valid(ov[5]), .out_ready(s_out_ready), .out_data(od[5]), .busy(bz[5]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one state on instance 0 and wait (bounded) for out_valid.
  // flip toggles in_inv right after acceptance; rdy_seen records any in_ready=1 meanwhile.
  task automatic xact_a(input logic [127:0] d, input logic inv, input logic flip,
                        output int lat, output logic rdy_seen);
    a_in_data  = d;
    a_in_inv   = inv;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_in_inv   = inv ^ flip;
    lat = 0;
    rdy_seen = 1'b0;
    while (!ov[0] && lat < 40) begin
      if (ir[0]) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    if (ir[0]) rdy_seen = 1'b1;
  endtask

  // Accept one state on instances 1..5 together and record each one's latency.
  task automatic xact_s(input logic [127:0] d, input logic inv);
    s_in_data  = d;
    s_in_inv   = inv;
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) first_done[i] = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      for (int i = 1; i < 6; i++)
        if (ov[i] && first_done[i] == 0) first_done[i] = k;
    end
  endtask

  task automatic drain_s();
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    chk("sweep_drain_ov", 128'(ov[5:1]), 128'h0);
  endtask

  initial begin
    int lat;
    logic rdy_seen;
    int bad;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_inv = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    s_in_valid = 1'b0; s_in_inv = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
    repeat (3) tick();
    chk("rst_in_ready", 128'(ir[0]), 128'h1);
    chk("rst_out_valid", 128'(ov[0]), 128'h0);
    chk("rst_out_data", od[0], 128'h0);
    chk("rst_busy", 128'(bz[0]), 128'h0);
    chk("rst_sweep_ready", 128'(ir[5:1]), 128'h1f);
    rst = 1'b0;
    tick();

    // Forward, LANES=4
    xact_a(PT, 1'b0, 1'b0, lat, rdy_seen);
    chk("fwd_latency", 128'(lat), 128'd4);
    chk("fwd_data", od[0], CT);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("fwd_hs_ov", 128'(ov[0]), 128'h0);
    chk("fwd_hs_ready", 128'(ir[0]), 128'h1);

    // Inverse, LANES=4, in_ready low throughout
    xact_a(CT, 1'b1, 1'b0, lat, rdy_seen);
    chk("inv_latency", 128'(lat), 128'd4);
    chk("inv_data", od[0], PT);
    chk("inv_ready_low", 128'(rdy_seen), 128'h0);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("inv_hs_ready", 128'(ir[0]), 128'h1);

    // Backpressure: hold DONE for 10 cycles with in_valid pulses arriving
    xact_a(PT, 1'b0, 1'b0, lat, rdy_seen);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      a_in_valid = ~a_in_valid;
      a_in_data  = {4{$urandom}};
      tick();
      if (od[0] !== CT || ov[0] !== 1'b1 || ir[0] !== 1'b0) bad++;
    end
    chk("bp_hold", 128'(bad), 128'h0);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("bp_release_ov", 128'(ov[0]), 128'h0);
    chk("bp_release_ready", 128'(ir[0]), 128'h1);
    repeat (3) tick();
    chk("bp_no_queue", 128'(bz[0]), 128'h0);

    // Reset two cycles after acceptance: immediate abort, no late out_valid
    a_in_data  = PT;
    a_in_inv   = 1'b0;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("midrst_ov", 128'(ov[0]), 128'h0);
    chk("midrst_data", od[0], 128'h0);
    chk("midrst_ready", 128'(ir[0]), 128'h1);
    chk("midrst_busy", 128'(bz[0]), 128'h0);
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      tick();
      if (ov[0]) bad++;
    end
    chk("midrst_no_pulse", 128'(bad), 128'h0);

    // After reset, with in_inv flipped during RUN: mode must stay forward
    xact_a(PT, 1'b0, 1'b1, lat, rdy_seen);
    chk("latch_latency", 128'(lat), 128'd4);
    chk("latch_data", od[0], CT);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // Lane sweep: all-zero forward
    xact_s(128'h0, 1'b0);
    for (int i = 1; i < 6; i++) begin
      chk($sformatf("sweep_fwd_lat%0d", i), 128'(first_done[i]), 128'(exp_lat[i]));
      chk($sformatf("sweep_fwd_data%0d", i), od[i], {16{8'h63}});
    end
    drain_s();

    // All-63 inverse; the forward-only instance applies the forward box instead
    xact_s({16{8'h63}}, 1'b1);
    for (int i = 1; i < 5; i++)
      chk($sformatf("sweep_inv_data%0d", i), od[i], 128'h0);
    chk("fwdonly_63", od[5], {16{8'hfb}});
    drain_s();

    // All-53 with in_inv=1 on the forward-only build
    xact_s({16{8'h53}}, 1'b1);
    chk("fwdonly_53", od[5], {16{8'hed}});
    chk("fwdonly_lat", 128'(first_done[5]), 128'd4);
    drain_s();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
